icache_line_fill: RTL and testbench

- Direct-mapped instruction cache sitting directly downstream of the IF-stage instruction fetch wrapper.
- Consumes the word address and read enable produced by IF; returns the instruction word plus a completion flag (rom_inst / irom_fin).
- On a miss, refills a whole line from the external instruction memory through a req/valid handshake.
- IF stalls the PC and flushes IF/ID while irom_fin is low.

---
 rtl/icache_pkg.sv | 10 +
 rtl/icache_tag_array.sv | 28 ++
 rtl/icache_line_fill.sv | 71 +++++++
 tb/tb_icache_line_fill.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, default geometry and tag-width helper
package icache_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, COMMIT = 2'd2} state_t;
  localparam int ADDR_W_DEF = 30;
  localparam int INDEX_W_DEF = 6;
  localparam int OFFSET_W_DEF = 2;
  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction
endpackage

// File: rtl/icache_tag_array.sv
// icache_tag_array: per-line valid/tag flops with combinational lookup
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W = tag_width(ADDR_W_DEF, INDEX_W_DEF, OFFSET_W_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  input  logic               wr_en,
  input  logic               wr_valid,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               clear
);
  logic [(1<<INDEX_W)-1:0] valid;
  logic [TAG_W-1:0] tags [1<<INDEX_W];
  assign hit = valid[rd_index] && tags[rd_index] == rd_tag;
  // clear wins over a same-cycle commit so an invalidated fill never becomes valid
  always_ff @(posedge clk)
    if (!rst || clear) valid <= '0;
    else if (wr_en && wr_valid) valid[wr_index] <= 1'b1;
  always_ff @(posedge clk)
    if (wr_en) tags[wr_index] <= wr_tag;
endmodule

// File: rtl/icache_line_fill.sv
// icache_line_fill: direct-mapped instruction cache, zero-latency hit,
// whole-line refill (word 0 upward) over a req/valid memory handshake
module icache_line_fill
  import icache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_ce,
  input  logic [ADDR_W-1:0] irom_addr,
  input  logic              inv,
  output logic [31:0]       rom_inst,
  output logic              irom_fin,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid
);
  localparam int TAG_W = tag_width(ADDR_W, INDEX_W, OFFSET_W);
  state_t state, state_nx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic [INDEX_W-1:0] index, fill_index;
  logic [OFFSET_W-1:0] offset, cnt;
  logic inv_pending, line_hit, hit, miss, last;
  logic [31:0] data [1<<(INDEX_W+OFFSET_W)];
  assign {tag, index, offset} = irom_addr;
  assign hit = state == IDLE && read_ce && line_hit;
  assign miss = state == IDLE && read_ce && !line_hit;
  assign last = mem_valid && &cnt;
  icache_tag_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tags (
    .clk(clk),
    .rst(rst),
    .rd_index(index),
    .rd_tag(tag),
    .hit(line_hit),
    .wr_en(state == COMMIT),
    .wr_valid(!inv_pending),
    .wr_index(fill_index),
    .wr_tag(fill_tag),
    .clear(inv)
  );
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (miss ? FILL : IDLE) : state == FILL ? (last ? COMMIT : FILL) : IDLE;
  always_comb begin
    irom_fin = rst && hit;
    rom_inst = irom_fin ? data[{index, offset}] : 32'h0;
    mem_req = state == FILL;
    mem_addr = mem_req ? {fill_tag, fill_index, cnt} : '0;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      cnt <= '0;
      inv_pending <= 1'b0;
      fill_tag <= '0;
      fill_index <= '0;
    end else begin
      if (miss) begin
        fill_tag <= tag;
        fill_index <= index;
        cnt <= '0;
      end else if (state == FILL && mem_valid) cnt <= cnt + 1'b1;
      inv_pending <= state == COMMIT ? 1'b0 : state == FILL ? inv_pending | inv : inv_pending;
    end
  always_ff @(posedge clk)
    if (rst && state == FILL && mem_valid) data[{fill_index, cnt}] <= mem_rdata;
endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill: vector table, hand-written corner sequences and random
// fetches checked against a line-level reference model of the cache
module tb_icache_line_fill;
  logic clk = 1'b0, rst, read_ce, inv, irom_fin, mem_req, mem_valid;
  logic [29:0] irom_addr, mem_addr;
  logic [31:0] rom_inst, mem_rdata;
  int n_chk = 0, n_pass = 0;
  bit m_valid [64];
  logic [21:0] m_tag [64];

  typedef struct {
    logic [29:0] addr;
    int gap;
    logic hit;
    logic [31:0] inst;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  icache_line_fill dut (
    .clk(clk), .rst(rst), .read_ce(read_ce), .irom_addr(irom_addr), .inv(inv),
    .rom_inst(rom_inst), .irom_fin(irom_fin), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  function automatic logic [31:0] mem_fn(input logic [29:0] a);
    if (a[29:2] == 28'h4) return 32'hA0 + 32'(a[1:0]);
    if (a[29:2] == 28'h44) return 32'hB0 + 32'(a[1:0]);
    return {a, 2'b01} ^ 32'h5EED_0000;
  endfunction

  function automatic bit model_hit(input logic [29:0] a);
    return m_valid[a[7:2]] && m_tag[a[7:2]] == a[29:8];
  endfunction

  task automatic model_fill(input logic [29:0] a);
    m_valid[a[7:2]] = 1'b1;
    m_tag[a[7:2]] = a[29:8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // one fetch: hold the address until irom_fin, serving refills with a fixed gap
  task automatic fetch(input logic [29:0] a, input int gap, input logic exp_hit, input logic [31:0] exp_inst);
    int w = 0, g = 0, cyc = 0;
    bit done = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      read_ce = 1'b1; irom_addr = a; inv = 1'b0;
      mem_valid = mem_req && g == gap;
      mem_rdata = mem_fn(mem_addr);
      #1;
      if (cyc == 0) check("hit_flag", irom_fin, exp_hit);
      if (mem_req) begin
        check("fill_addr", mem_addr, {a[29:2], 2'(w)});
        if (mem_valid) begin w++; g = 0; end else g++;
      end
      if (irom_fin) begin
        check("rom_inst", rom_inst, exp_inst);
        check("fill_words", w, exp_hit ? 0 : 4);
        check("latency", cyc, exp_hit ? 0 : 4 * (gap + 1) + 2);
        check("req_idle", mem_req, 0);
        done = 1;
      end else check("inst_zero", rom_inst, 0);
      cyc++;
    end
    if (!done) check("fetch_timeout", 0, 1);
    mem_valid = 1'b0;
  endtask

  // miss on a, switching the presented address to a2 after sw words, optional inv pulse
  task automatic fill_seq(input logic [29:0] a, input logic [29:0] a2, input int sw, input int gap, input int inv_at);
    int w = 0, g = 0, cyc = 0;
    while (w < 4 && cyc < 100) begin
      @(negedge clk);
      read_ce = 1'b1; irom_addr = w >= sw ? a2 : a; inv = cyc == inv_at;
      mem_valid = mem_req && g == gap;
      mem_rdata = mem_fn(mem_addr);
      #1;
      check("fill_fin", irom_fin, 0);
      if (mem_req) begin
        check("fill_line_addr", mem_addr, {a[29:2], 2'(w)});
        if (mem_valid) begin w++; g = 0; end else g++;
      end
      cyc++;
    end
    check("fill_done", w, 4);
    @(negedge clk);
    inv = 1'b0; mem_valid = 1'b0;
    #1;
    check("commit_req", mem_req, 0);
    check("commit_fin", irom_fin, 0);
  endtask

  initial begin
    logic [29:0] a;
    int w, cyc;
    vecs[0] = '{30'h10, 0, 1'b0, 32'hA0};
    vecs[1] = '{30'h12, 0, 1'b1, 32'hA2};
    vecs[2] = '{30'h110, 1, 1'b0, 32'hB0};
    vecs[3] = '{30'h10, 0, 1'b0, 32'hA0};
    vecs[4] = '{30'h13, 0, 1'b1, 32'hA3};
    model_clear();
    rst = 1'b0; read_ce = 1'b0; irom_addr = 30'h10; inv = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    read_ce = 1'b1;
    #1;
    check("rst_fin", irom_fin, 0);
    check("rst_inst", rom_inst, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    read_ce = 1'b0; rst = 1'b1;

    foreach (vecs[i]) begin
      fetch(vecs[i].addr, vecs[i].gap, vecs[i].hit, vecs[i].inst);
      check("vec_model", model_hit(vecs[i].addr), vecs[i].hit);
      model_fill(vecs[i].addr);
    end

    // backpressure with an address change mid-fill
    fill_seq(30'h30, 30'h200, 2, 2, -1);
    model_fill(30'h30);
    fetch(30'h200, 0, 1'b0, mem_fn(30'h200));
    model_fill(30'h200);
    fetch(30'h31, 0, 1'b1, mem_fn(30'h31));

    // invalidate during FILL: the filled line and all older lines miss
    fill_seq(30'h20, 30'h20, 4, 0, 2);
    model_clear();
    fetch(30'h20, 0, 1'b0, mem_fn(30'h20));
    fetch(30'h10, 0, 1'b0, 32'hA0);
    model_fill(30'h20);
    model_fill(30'h10);

    // invalidate in IDLE alongside a miss: the miss still fills and validates
    fill_seq(30'h50, 30'h50, 4, 1, 0);
    model_clear();
    model_fill(30'h50);
    fetch(30'h20, 0, 1'b0, mem_fn(30'h20));
    fetch(30'h51, 0, 1'b1, mem_fn(30'h51));
    model_fill(30'h20);

    // reset after the second refill word
    w = 0; cyc = 0;
    while (w < 2 && cyc < 50) begin
      @(negedge clk);
      read_ce = 1'b1; irom_addr = 30'h40; inv = 1'b0;
      mem_valid = mem_req; mem_rdata = mem_fn(mem_addr);
      #1;
      if (mem_valid) w++;
      cyc++;
    end
    check("pre_rst_words", w, 2);
    @(negedge clk);
    rst = 1'b0; mem_valid = 1'b0;
    #1;
    check("rst_hold_fin", irom_fin, 0);
    check("rst_hold_inst", rom_inst, 0);
    @(negedge clk);
    read_ce = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_addr", mem_addr, 0);
    check("rst_mid_fin", irom_fin, 0);
    rst = 1'b1;
    model_clear();
    fetch(30'h40, 0, 1'b0, mem_fn(30'h40));
    model_fill(30'h40);
    fetch(30'h10, 0, 1'b0, 32'hA0);
    model_fill(30'h10);

    // random fetches against the line-level model
    for (int i = 0; i < 60; i++) begin
      a = 30'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        read_ce = 1'b0; irom_addr = a; mem_valid = 1'b0;
        inv = 1'($urandom_range(0, 1));
        #1;
        check("idle_fin", irom_fin, 0);
        if (inv) model_clear();
      end
      fetch(a, $urandom_range(0, 2), model_hit(a), mem_fn(a));
      model_fill(a);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
